// File: rtl/matrix_storage_loader.sv
// Host-side write initiator for one matrix storage: turns a stream of row words into
// storage write transactions (is_write, layer/row index, data) after a locator reset.
module matrix_storage_loader #(
    parameter int unsigned DATA_WIDTH  = 48,
    parameter int unsigned INDEX_WIDTH = 32
) (
    input  logic                   clk_clk,
    input  logic                   reset_reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [INDEX_WIDTH-1:0] cfg_num_layers,
    input  logic [INDEX_WIDTH-1:0] cfg_rows_per_layer,
    input  logic                   in_valid,
    input  logic [DATA_WIDTH-1:0]  in_data,
    output logic                   in_ready,
    output logic                   locator_reset,
    output logic                   is_write,
    output logic [INDEX_WIDTH-1:0] write_layer_index,
    output logic [INDEX_WIDTH-1:0] write_row_index,
    output logic [DATA_WIDTH-1:0]  write_data,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {StIdle, StClear, StLoad, StDone} state_e;

    state_e                 state_q;
    logic [INDEX_WIDTH-1:0] layers_q;
    logic [INDEX_WIDTH-1:0] rows_q;
    logic [INDEX_WIDTH-1:0] layer_q;
    logic [INDEX_WIDTH-1:0] row_q;
    logic                   last_row;
    logic                   last_layer;

    assign in_ready   = (state_q == StLoad);
    assign busy       = (state_q != StIdle);
    assign last_row   = (row_q == rows_q - INDEX_WIDTH'(1));
    assign last_layer = (layer_q == layers_q - INDEX_WIDTH'(1));

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q           <= StIdle;
            layers_q          <= '0;
            rows_q            <= '0;
            layer_q           <= '0;
            row_q             <= '0;
            locator_reset     <= 1'b0;
            is_write          <= 1'b0;
            write_layer_index <= '0;
            write_row_index   <= '0;
            write_data        <= '0;
            done              <= 1'b0;
        end else begin
            // Pulse outputs default low; index/data hold their last write.
            locator_reset <= 1'b0;
            is_write      <= 1'b0;
            done          <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        layers_q <= cfg_num_layers;
                        rows_q   <= cfg_rows_per_layer;
                        layer_q  <= '0;
                        row_q    <= '0;
                        if (cfg_num_layers == '0 || cfg_rows_per_layer == '0) begin
                            state_q <= StDone;
                            done    <= 1'b1;
                        end else begin
                            state_q       <= StClear;
                            locator_reset <= 1'b1;
                        end
                    end
                end
                StClear: begin
                    layer_q <= '0;
                    row_q   <= '0;
                    state_q <= abort ? StIdle : StLoad;
                end
                StLoad: begin
                    if (abort) begin
                        state_q <= StIdle;
                    end else if (in_valid) begin
                        is_write          <= 1'b1;
                        write_layer_index <= layer_q;
                        write_row_index   <= row_q;
                        write_data        <= in_data;
                        if (last_row) begin
                            row_q   <= '0;
                            layer_q <= layer_q + INDEX_WIDTH'(1);
                            if (last_layer) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end
                        end else begin
                            row_q <= row_q + INDEX_WIDTH'(1);
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_storage_loader.sv
// Self-checking bench for matrix_storage_loader: randomized stream stimulus checked
// against a layer/row enumeration model of the image.
module tb_matrix_storage_loader;

    localparam int DW = 48;
    localparam int IW = 32;
    localparam int WW = 2 * IW + DW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [IW-1:0] cfg_l = '0;
    logic [IW-1:0] cfg_r = '0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          locator_reset;
    logic          is_write;
    logic [IW-1:0] write_layer_index;
    logic [IW-1:0] write_row_index;
    logic [DW-1:0] write_data;
    logic          busy;
    logic          done;

    matrix_storage_loader #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) dut (
        .clk_clk            (clk),
        .reset_reset_n      (reset_n),
        .start              (start),
        .abort              (abort),
        .cfg_num_layers     (cfg_l),
        .cfg_rows_per_layer (cfg_r),
        .in_valid           (in_valid),
        .in_data            (in_data),
        .in_ready           (in_ready),
        .locator_reset      (locator_reset),
        .is_write           (is_write),
        .write_layer_index  (write_layer_index),
        .write_row_index    (write_row_index),
        .write_data         (write_data),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;
    int s_cyc;

    logic [DW-1:0] data_q[$];
    logic [WW-1:0] wr_q[$];
    int done_cnt, lr_cnt, done_cyc, lr_cyc, ready_cyc, first_wr_cyc, last_wr_cyc, fall_cyc;
    int hold_bad;
    bit hold_chk = 0;
    bit busy_prev = 0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (is_write) begin
                if (wr_q.size() == 0) first_wr_cyc = cyc;
                wr_q.push_back({write_layer_index, write_row_index, write_data});
                last_wr_cyc = cyc;
            end else if (hold_chk && wr_q.size() > 0 &&
                         {write_layer_index, write_row_index, write_data} !== wr_q[$]) begin
                hold_bad++;
            end
            if (done) begin done_cnt++; done_cyc = cyc; end
            if (locator_reset) begin lr_cnt++; lr_cyc = cyc; end
            if (in_ready && ready_cyc < 0) ready_cyc = cyc;
            if (busy_prev && !busy && fall_cyc < 0) fall_cyc = cyc;
            busy_prev = busy;
        end
    end

    // Reference: the k-th accepted word lands at layer k/rows, row k%rows.
    function automatic logic [WW-1:0] model_write(input int k, input int rows);
        return {IW'(k / rows), IW'(k % rows), data_q[k]};
    endfunction

    task automatic clear_mon();
        wr_q.delete();
        done_cnt = 0; lr_cnt = 0; hold_bad = 0;
        done_cyc = -1; lr_cyc = -1; ready_cyc = -1;
        first_wr_cyc = -1; last_wr_cyc = -1; fall_cyc = -1;
        busy_prev = busy;
    endtask

    task automatic make_data(input int n, input bit seq);
        data_q.delete();
        for (int k = 0; k < n; k++) data_q.push_back(seq ? DW'(k + 1) : DW'({$urandom, $urandom}));
    endtask

    task automatic do_start(input int l, input int r);
        clear_mon();
        cfg_l = IW'(l); cfg_r = IW'(r); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; s_cyc = cyc;
        cfg_l = $urandom; cfg_r = $urandom;
    endtask

    task automatic feed(input int n, input int mode, input int abort_at, input int restart_at);
        int sent;
        int guard;
        bit tog;
        bit acc;
        sent = 0; guard = 0; tog = 1'b1;
        while (sent < n) begin
            if (guard > 400) begin
                n_chk++;
                $display("FAIL feed_timeout: sent %0d words, required %0d", sent, n);
                break;
            end
            guard++;
            in_valid = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            in_data = data_q[sent];
            if (sent == abort_at) begin abort = 1'b1; in_valid = 1'b1; end
            if (sent == restart_at) begin start = 1'b1; cfg_l = 9; cfg_r = 1; end
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            start = 1'b0;
            if (abort) begin abort = 1'b0; break; end
            if (acc) sent++;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #12;
        n_chk++; if ({is_write, locator_reset, done, busy, in_ready} !== 5'b0)
            $display("FAIL rst_flags: got %b required 00000", {is_write, locator_reset, done, busy, in_ready}); else n_pass++;
        n_chk++; if ({write_layer_index, write_row_index, write_data} !== '0)
            $display("FAIL rst_outputs: got %h required 0", {write_layer_index, write_row_index, write_data}); else n_pass++;
        @(negedge clk); reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++; if (busy !== 1'b0 || is_write !== 1'b0)
            $display("FAIL rst_idle: busy %b is_write %b required 0 0", busy, is_write); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        make_data(6, 1);
        do_start(2, 3);
        feed(6, 0, -1, -1);
        repeat (3) @(negedge clk);
        n_chk++; if (wr_q.size() != 6) $display("FAIL t1_count: got %0d required 6", wr_q.size()); else n_pass++;
        for (int k = 0; k < 6 && k < wr_q.size(); k++) begin
            n_chk++; if (wr_q[k] !== model_write(k, 3))
                $display("FAIL t1_write%0d: got %h required %h", k, wr_q[k], model_write(k, 3)); else n_pass++;
        end
        n_chk++; if (lr_cnt != 1 || lr_cyc != s_cyc)
            $display("FAIL t1_locator: got cnt %0d cyc %0d required 1 %0d", lr_cnt, lr_cyc, s_cyc); else n_pass++;
        n_chk++; if (ready_cyc != s_cyc + 1) $display("FAIL t1_ready: got %0d required %0d", ready_cyc, s_cyc + 1); else n_pass++;
        n_chk++; if (first_wr_cyc != s_cyc + 2 || last_wr_cyc != s_cyc + 7)
            $display("FAIL t1_timing: got %0d..%0d required %0d..%0d", first_wr_cyc, last_wr_cyc, s_cyc + 2, s_cyc + 7); else n_pass++;
        n_chk++; if (done_cnt != 1 || done_cyc != last_wr_cyc)
            $display("FAIL t1_done: got cnt %0d cyc %0d required 1 %0d", done_cnt, done_cyc, last_wr_cyc); else n_pass++;
        n_chk++; if (fall_cyc != s_cyc + 8) $display("FAIL t1_busy_fall: got %0d required %0d", fall_cyc, s_cyc + 8); else n_pass++;
    endtask

    task automatic test_toggle();
        make_data(6, 1);
        hold_chk = 1'b1;
        do_start(2, 3);
        feed(6, 1, -1, -1);
        repeat (3) @(negedge clk);
        hold_chk = 1'b0;
        n_chk++; if (wr_q.size() != 6) $display("FAIL t2_count: got %0d required 6", wr_q.size()); else n_pass++;
        for (int k = 0; k < 6 && k < wr_q.size(); k++) begin
            n_chk++; if (wr_q[k] !== model_write(k, 3))
                $display("FAIL t2_write%0d: got %h required %h", k, wr_q[k], model_write(k, 3)); else n_pass++;
        end
        n_chk++; if (first_wr_cyc != s_cyc + 3 || last_wr_cyc != s_cyc + 13)
            $display("FAIL t2_spacing: got %0d..%0d required %0d..%0d", first_wr_cyc, last_wr_cyc, s_cyc + 3, s_cyc + 13); else n_pass++;
        n_chk++; if (hold_bad != 0) $display("FAIL t2_hold: got %0d changes required 0", hold_bad); else n_pass++;
        n_chk++; if (done_cnt != 1 || done_cyc != last_wr_cyc)
            $display("FAIL t2_done: got cnt %0d cyc %0d required 1 %0d", done_cnt, done_cyc, last_wr_cyc); else n_pass++;
    endtask

    task automatic test_zero_count();
        int cfgs[4];
        cfgs = '{0, 5, 3, 0};
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            do_start(cfgs[2*i], cfgs[2*i+1]);
            repeat (4) @(negedge clk);
            in_valid = 1'b0;
            n_chk++; if (lr_cnt != 0 || wr_q.size() != 0)
                $display("FAIL t3_nowrite%0d: got lr %0d writes %0d required 0 0", i, lr_cnt, wr_q.size()); else n_pass++;
            n_chk++; if (done_cnt != 1 || done_cyc != s_cyc)
                $display("FAIL t3_done%0d: got cnt %0d cyc %0d required 1 %0d", i, done_cnt, done_cyc, s_cyc); else n_pass++;
            n_chk++; if (busy !== 1'b0) $display("FAIL t3_idle%0d: got busy %b required 0", i, busy); else n_pass++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_restart_ignored();
        make_data(4, 0);
        do_start(1, 4);
        feed(4, 0, -1, 2);
        repeat (6) @(negedge clk);
        n_chk++; if (wr_q.size() != 4) $display("FAIL t4_count: got %0d required 4", wr_q.size()); else n_pass++;
        for (int k = 0; k < 4 && k < wr_q.size(); k++) begin
            n_chk++; if (wr_q[k] !== model_write(k, 4))
                $display("FAIL t4_write%0d: got %h required %h", k, wr_q[k], model_write(k, 4)); else n_pass++;
        end
        n_chk++; if (done_cnt != 1 || busy !== 1'b0)
            $display("FAIL t4_done: got cnt %0d busy %b required 1 0", done_cnt, busy); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_abort();
        make_data(4, 0);
        do_start(1, 4);
        feed(4, 0, 2, -1);
        @(negedge clk);
        n_chk++; if (busy !== 1'b0 || is_write !== 1'b0)
            $display("FAIL t5_idle: got busy %b is_write %b required 0 0", busy, is_write); else n_pass++;
        repeat (3) @(negedge clk);
        n_chk++; if (wr_q.size() != 2 || done_cnt != 0)
            $display("FAIL t5_abort: got writes %0d done %0d required 2 0", wr_q.size(), done_cnt); else n_pass++;
        for (int k = 0; k < 2 && k < wr_q.size(); k++) begin
            n_chk++; if (wr_q[k] !== model_write(k, 4))
                $display("FAIL t5_write%0d: got %h required %h", k, wr_q[k], model_write(k, 4)); else n_pass++;
        end
        @(posedge clk); #1;
        make_data(1, 0);
        do_start(1, 1);
        feed(1, 0, -1, -1);
        repeat (3) @(negedge clk);
        n_chk++; if (wr_q.size() != 1 || done_cnt != 1)
            $display("FAIL t5_reload: got writes %0d done %0d required 1 1", wr_q.size(), done_cnt); else n_pass++;
        if (wr_q.size() > 0) begin
            n_chk++; if (wr_q[0] !== model_write(0, 1))
                $display("FAIL t5_reload_write: got %h required %h", wr_q[0], model_write(0, 1)); else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_load();
        make_data(6, 0);
        do_start(2, 3);
        feed(2, 0, -1, -1);
        #2 reset_n = 1'b0;
        #1;
        n_chk++; if ({is_write, locator_reset, done, busy, in_ready} !== 5'b0)
            $display("FAIL t6_flags: got %b required 00000", {is_write, locator_reset, done, busy, in_ready}); else n_pass++;
        n_chk++; if ({write_layer_index, write_row_index, write_data} !== '0)
            $display("FAIL t6_outputs: got %h required 0", {write_layer_index, write_row_index, write_data}); else n_pass++;
        @(negedge clk); reset_n = 1'b1;
        clear_mon();
        in_valid = 1'b1; in_data = data_q[2];
        repeat (6) @(negedge clk);
        in_valid = 1'b0;
        n_chk++; if (wr_q.size() != 0 || busy !== 1'b0 || lr_cnt != 0)
            $display("FAIL t6_quiet: got writes %0d busy %b lr %0d required 0 0 0", wr_q.size(), busy, lr_cnt); else n_pass++;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int l;
            int r;
            l = $urandom_range(1, 3);
            r = $urandom_range(1, 4);
            make_data(l * r, 0);
            do_start(l, r);
            feed(l * r, 2, -1, -1);
            repeat (3) @(negedge clk);
            n_chk++; if (wr_q.size() != l * r || done_cnt != 1)
                $display("FAIL rnd%0d_count: got writes %0d done %0d required %0d 1", it, wr_q.size(), done_cnt, l * r); else n_pass++;
            for (int k = 0; k < l * r && k < wr_q.size(); k++) begin
                n_chk++; if (wr_q[k] !== model_write(k, r))
                    $display("FAIL rnd%0d_write%0d: got %h required %h", it, k, wr_q[k], model_write(k, r)); else n_pass++;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_toggle();
        test_zero_count();
        test_restart_ignored();
        test_abort();
        test_reset_mid_load();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/matrix_storage_loader.md
Name: matrix_storage_loader

Overview:
Host-side write initiator for the matrix storages: input, label and weight. It accepts a valid/ready stream of 48-bit row words for one matrix image. Each word is converted into a storage write transaction: is_write pulse, layer index, row index and data, in the same form the data path's storage write interfaces consume. It also issues the one-cycle matrix storage locator reset before loading. One instance drives one storage; the top level instantiates it per storage.

Parameters:
DATA_WIDTH, 48, width of one matrix row word.
INDEX_WIDTH, 32, width of layer/row indices and configuration counts.

Ports:
clk_clk  in  1  clock; all logic on rising edge.
reset_reset_n  in  1  asynchronous active-low reset.
start  in  1  one-cycle request to begin a load; sampled only in IDLE.
abort  in  1  synchronous cancel of a load in progress.
cfg_num_layers  in  INDEX_WIDTH  layers in the image; latched on accepted start.
cfg_rows_per_layer  in  INDEX_WIDTH  rows per layer; latched on accepted start.
in_valid  in  1  stream word valid.
in_data  in  DATA_WIDTH  stream row word.
in_ready  out  1  loader accepts a word this cycle.
locator_reset  out  1  one-cycle pulse to the storage locator reset.
is_write  out  1  storage write strobe, one cycle per row.
write_layer_index  out  INDEX_WIDTH  layer of the current write.
write_row_index  out  INDEX_WIDTH  row of the current write.
write_data  out  DATA_WIDTH  row word of the current write.
busy  out  1  high from an accepted start until return to IDLE.
done  out  1  one-cycle pulse when all rows of the image have been written.

Behaviour:
- Reset (asynchronous, reset_reset_n=0):
  - State IDLE.
  - All outputs 0, including indices and data.
  - Internal counters and latched configuration cleared.
- States: IDLE, CLEAR, LOAD, DONE.
- Outputs are registered except in_ready, which is high only in state LOAD.
- busy = (state != IDLE).
- IDLE + start=1:
  - Latch both configuration counts.
  - If either count is 0: go to DONE. No locator_reset, no writes.
  - Otherwise: go to CLEAR.
- CLEAR (exactly 1 cycle):
  - locator_reset=1.
  - Layer and row counters set to 0.
  - Next state LOAD.
- LOAD, accept condition in_valid & in_ready:
  - Next cycle: is_write=1, write_data=in_data, write_layer_index/write_row_index = counter values at acceptance.
  - Latency from accept to is_write is exactly 1 cycle.
  - Back-to-back accepts produce back-to-back write pulses.
  - A cycle with no accept produces is_write=0 next cycle; index and data outputs hold their last values.
- Counter advance on each accept:
  - row = rows-1: row wraps to 0 and layer increments.
  - Otherwise row increments.
  - Never exceeds configured bounds; no modular overflow possible within bounds.
- Final accept (layer = layers-1 and row = rows-1) at cycle T:
  - State is DONE at T+1, with the last is_write pulse and done=1 in the same cycle T+1.
  - IDLE at T+2; in_ready low from T+1.
- DONE always lasts 1 cycle, with done=1. The zero-count path also emits done one cycle after start.
- start in any state other than IDLE is ignored. Configuration changes during a load are ignored.
- abort=1 in CLEAR or LOAD:
  - Next state IDLE; no done pulse.
  - A word accepted in the same cycle is discarded: is_write=0 next cycle.
- abort in IDLE or DONE has no effect; DONE still pulses done.
- abort and start together in IDLE: start wins.
- in_data is sampled only on accept. in_valid may be held while in_ready is low with no effect.
- Reset asserted mid-load clears everything immediately.
  - No further writes occur; a partially written image is not rolled back.

Test Plan:
1. layers=2, rows=3, in_valid held high with data 0x1..0x6 -> locator_reset 1 cycle, then 6 consecutive is_write pulses with (layer,row,data): (0,0,1) (0,1,2) (0,2,3) (1,0,4) (1,1,5) (1,2,6); done coincides with the 6th pulse; busy low next cycle.
2. Same config, in_valid toggled 1/0 each cycle -> 6 writes spaced every other cycle, identical indices and data; outputs hold between pulses.
3. layers=0, rows=5 start -> no locator_reset, no is_write, done=1 the cycle after start; layers=3, rows=0 -> same.
4. start re-pulsed with layers=9 mid-load of a 1x4 image -> exactly 4 writes, row 0..3, done once.
5. abort after 2 of 4 accepts, with in_valid also high in the abort cycle -> exactly 2 writes, no done, IDLE and busy=0 next cycle; a new 1x1 load then writes (0,0) correctly.
6. reset_reset_n pulsed low mid-load -> all outputs 0 asynchronously, no is_write after release until a new start.
